// File: rtl/ingress_pkt_stager.sv
// rtl/ingress_pkt_stager.sv - store-and-forward packet staging buffer ahead of the NIC FIFO FSM
//
// Purpose:
//   Buffers whole NetFPGA-style packets (64-bit data + 8-bit ctrl) from the MAC
//   side and releases each one to the FIFO FSM only once it is complete, as a
//   single gap-free burst. Packets longer than MAX_PKT_WORDS are discarded.
//   After every burst the read side waits HOLDOFF cycles so the FSM's
//   registered in_rdy cannot let a second packet start on stale information.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_data/in_ctrl     upstream word, accepted when in_wr & in_rdy
//   in_wr, in_rdy       upstream valid / registered space-available
//   out_data/out_ctrl   word to FSM (registered, held while out_wr=0)
//   out_wr, out_rdy     word valid to FSM / FSM ready (sampled in IDLE only)
//   pkt_fwd_count       saturating count of forwarded packets
//   pkt_drop_count      saturating count of dropped over-length packets
//   wr_err              sticky: in_wr seen while in_rdy=0
//
// Build option:
//   STAGER_STATS_EN     when defined, pkt_fwd_count / pkt_drop_count are live;
//                       otherwise both are tied to zero.

module ingress_pkt_stager #(
  parameter int ADDR_W        = 8,
  parameter int MAX_PKT_WORDS = 255,
  parameter int HOLDOFF       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_ctrl,
  input  logic        in_wr,
  output logic        in_rdy,
  output logic [63:0] out_data,
  output logic [7:0]  out_ctrl,
  output logic        out_wr,
  input  logic        out_rdy,
  output logic [15:0] pkt_fwd_count,
  output logic [15:0] pkt_drop_count,
  output logic        wr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int HW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [ADDR_W:0] MAX_W     = (ADDR_W+1)'(MAX_PKT_WORDS);
  localparam logic [HW-1:0]   HCNT_LAST = HW'(HOLDOFF - 1);

  if (MAX_PKT_WORDS > DEPTH - 1) begin : g_bad_max
    $error("MAX_PKT_WORDS must not exceed 2**ADDR_W - 1");
  end
  if (MAX_PKT_WORDS < 2) begin : g_bad_min
    $error("MAX_PKT_WORDS must be at least 2");
  end
  if (HOLDOFF < 1) begin : g_bad_hold
    $error("HOLDOFF must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} state_t;

  // Each entry is {ctrl, data}.
  logic [71:0] mem [DEPTH];

  logic [ADDR_W-1:0] wp, wp_start, rp;
  logic [ADDR_W:0]   used, used_next;
  logic [ADDR_W:0]   pkt_len;   // words of the current packet already stored
  logic [ADDR_W:0]   pkt_cnt;   // complete packets waiting to be sent
  logic              drop;

  state_t            state, state_next;
  logic [HW-1:0]     hcnt, hcnt_next;

  logic        wr_acc, in_eop, overflow, store, commit;
  logic        issue, eop_sent;
  logic [71:0] rd_word;

  assign wr_acc = in_wr & in_rdy;
  assign in_eop = (in_ctrl != 8'h00);
  // Accepting word MAX_PKT_WORDS+1 means the packet is over length. Because
  // pkt_len only reaches MAX_W without a commit, the earlier words had no EOP.
  assign overflow = wr_acc & ~drop & (pkt_len == MAX_W);
  assign store    = wr_acc & ~drop & ~overflow;
  // The header may carry any ctrl value; only later words can end a packet.
  assign commit   = store & (pkt_len != '0) & in_eop;
  // Only committed words are ever addressed by rp, so this never reads a
  // location being written in the same cycle.
  assign rd_word  = mem[rp];

  // Read FSM: next state and issue decisions.
  always_comb begin
    state_next = state;
    hcnt_next  = hcnt;
    issue      = 1'b0;
    eop_sent   = 1'b0;
    case (state)
      S_IDLE: begin
        if ((pkt_cnt != '0) && out_rdy) begin
          issue      = 1'b1;          // header goes out on this edge
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        issue = 1'b1;                 // no gaps, out_rdy not consulted
        if (rd_word[71:64] != 8'h00) begin
          eop_sent   = 1'b1;
          state_next = S_HOLD;
          hcnt_next  = '0;
        end
      end
      S_HOLD: begin
        if (hcnt == HCNT_LAST) state_next = S_IDLE;
        else                   hcnt_next  = hcnt + HW'(1);
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      hcnt  <= '0;
    end else begin
      state <= state_next;
      hcnt  <= hcnt_next;
    end
  end

  // Occupancy counts every stored word, committed or not; a rewind returns
  // the aborted packet's words.
  always_comb begin
    used_next = used;
    if (store)    used_next = used_next + (ADDR_W+1)'(1);
    if (issue)    used_next = used_next - (ADDR_W+1)'(1);
    if (overflow) used_next = used_next - pkt_len;
  end

  always_ff @(posedge clk) begin
    if (store) mem[wp] <= {in_ctrl, in_data};
  end

  // Write side, packet bookkeeping and read pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp       <= '0;
      wp_start <= '0;
      rp       <= '0;
      used     <= '0;
      pkt_len  <= '0;
      pkt_cnt  <= '0;
      drop     <= 1'b0;
      in_rdy   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      used   <= used_next;
      // used never exceeds DEPTH, so its top bit is set exactly when full.
      in_rdy <= ~used_next[ADDR_W];
      if (in_wr && !in_rdy) wr_err <= 1'b1;

      if (store) begin
        wp <= wp + ADDR_W'(1);
        if (commit) begin
          wp_start <= wp + ADDR_W'(1);
          pkt_len  <= '0;
        end else begin
          pkt_len <= pkt_len + (ADDR_W+1)'(1);
        end
      end

      if (overflow) begin
        wp      <= wp_start;
        pkt_len <= '0;
        // If the offending word is itself the EOP there is nothing left to skip.
        drop    <= ~in_eop;
      end else if (wr_acc && drop && in_eop) begin
        drop <= 1'b0;
      end

      if (issue) rp <= rp + ADDR_W'(1);

      if (commit && !eop_sent)      pkt_cnt <= pkt_cnt + (ADDR_W+1)'(1);
      else if (!commit && eop_sent) pkt_cnt <= pkt_cnt - (ADDR_W+1)'(1);
    end
  end

  // Registered outputs; data holds its last value between bursts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= issue;
      if (issue) {out_ctrl, out_data} <= rd_word;
    end
  end

`ifdef STAGER_STATS_EN
  logic drop_evt;
  assign drop_evt = (overflow & in_eop) | (wr_acc & drop & in_eop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_fwd_count  <= '0;
      pkt_drop_count <= '0;
    end else begin
      if (eop_sent && (pkt_fwd_count != 16'hFFFF))
        pkt_fwd_count <= pkt_fwd_count + 16'd1;
      if (drop_evt && (pkt_drop_count != 16'hFFFF))
        pkt_drop_count <= pkt_drop_count + 16'd1;
    end
  end
`else
  assign pkt_fwd_count  = 16'h0000;
  assign pkt_drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ingress_pkt_stager.sv
// tb/tb_ingress_pkt_stager.sv - self-checking bench for ingress_pkt_stager

module tb_ingress_pkt_stager;

  localparam int ADDR_W        = 8;
  localparam int MAX_PKT_WORDS = 255;
  localparam int HOLDOFF       = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b0;
  logic [15:0] pkt_fwd_count;
  logic [15:0] pkt_drop_count;
  logic        wr_err;

  ingress_pkt_stager #(
    .ADDR_W(ADDR_W), .MAX_PKT_WORDS(MAX_PKT_WORDS), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .pkt_fwd_count(pkt_fwd_count), .pkt_drop_count(pkt_drop_count), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model: expected output words in order, {is_eop, ctrl, data},
  // plus packet-level forward/drop tallies since the last reset.
  logic [72:0] exp_q[$];
  int exp_fwd  = 0;
  int exp_drop = 0;

  // Observed burst timing.
  int burst_start[$];
  int burst_end[$];
  bit in_pkt    = 1'b0;
  bit have_prev = 1'b0;
  int last_end  = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] stat(input int n);
`ifdef STAGER_STATS_EN
    return 16'(n);
`else
    return 16'h0000 & 16'(n);
`endif
  endfunction

  // Output monitor: every word must match the model, bursts must be gap-free
  // and separated by at least HOLDOFF idle cycles.
  always @(negedge clk) begin : mon
    logic [72:0] w;
    if (reset) begin
      in_pkt    = 1'b0;
      have_prev = 1'b0;
    end else if (out_wr) begin
      if (!in_pkt) begin
        in_pkt = 1'b1;
        burst_start.push_back(cyc);
        if (have_prev) check("holdoff", 72'((cyc - last_end - 1) >= HOLDOFF), 72'd1);
      end
      if (exp_q.size() == 0) begin
        check("spurious out_wr", 72'(out_wr), 72'd0);
      end else begin
        w = exp_q.pop_front();
        check("out word", {out_ctrl, out_data}, w[71:0]);
        if (w[72]) begin
          in_pkt    = 1'b0;
          have_prev = 1'b1;
          last_end  = cyc;
          burst_end.push_back(cyc);
        end
      end
    end else if (in_pkt) begin
      check("burst gap", 72'(out_wr), 72'd1);
      in_pkt = 1'b0;
    end
  end

  task automatic send_word(input logic [7:0] c, input logic [63:0] d);
    check("in_rdy before write", 72'(in_rdy), 72'd1);
    in_ctrl = c;
    in_data = d;
    in_wr   = 1'b1;
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  // Builds a packet of len words, registers it with the model, drives it.
  task automatic send_pkt(input int len, input logic [7:0] hdr, input logic [7:0] eop,
                          input int gap_pct, input bit rdy_rand);
    logic [72:0] words[$];
    logic [7:0]  c;
    for (int i = 0; i < len; i++) begin
      c = (i == 0) ? hdr : ((i == len - 1) ? eop : 8'h00);
      words.push_back({(i == len - 1), c, {$urandom, $urandom}});
    end
    if (len <= MAX_PKT_WORDS) begin
      foreach (words[i]) exp_q.push_back(words[i]);
      exp_fwd++;
    end else begin
      exp_drop++;
    end
    foreach (words[i]) begin
      if (rdy_rand) out_rdy = 1'($urandom_range(0, 1));
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        @(posedge clk); #1;
      end
      send_word(words[i][71:64], words[i][63:0]);
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int k = 0;
    while ((exp_q.size() != 0 || in_pkt) && k < max_cyc) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", 72'(exp_q.size()), 72'd0);
    repeat (HOLDOFF + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, e_a, e_b, seen;
    logic [7:0]  xc, ec;
    logic [63:0] xd, ed;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst out_wr", 72'(out_wr), 72'd0);
    check("rst out_data", 72'(out_data), 72'd0);
    check("rst out_ctrl", 72'(out_ctrl), 72'd0);
    check("rst in_rdy", 72'(in_rdy), 72'd0);
    check("rst wr_err", 72'(wr_err), 72'd0);
    check("rst fwd", 72'(pkt_fwd_count), 72'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("release in_rdy", 72'(in_rdy), 72'd1);

    // Single 4-word packet: exact burst timing.
    out_rdy = 1'b1;
    nb = burst_start.size();
    send_pkt(4, 8'hFF, 8'h01, 0, 1'b0);
    e_a = cyc;
    repeat (8) @(posedge clk);
    #1;
    check("t1 bursts", 72'(burst_start.size()), 72'(nb + 1));
    if (burst_end.size() > nb) begin
      check("t1 first", 72'(burst_start[nb]), 72'(e_a + 1));
      check("t1 last", 72'(burst_end[nb]), 72'(e_a + 4));
    end
    check("t1 fwd count", 72'(pkt_fwd_count), 72'(stat(exp_fwd)));
    wait_drain(100);

    // Three back-to-back 2-word packets: exactly HOLDOFF idle cycles between.
    nb = burst_start.size();
    for (int p = 0; p < 3; p++) send_pkt(2, 8'($urandom), 8'($urandom_range(1, 255)), 0, 1'b0);
    wait_drain(100);
    check("t2 bursts", 72'(burst_start.size()), 72'(nb + 3));
    if (burst_start.size() >= nb + 3) begin
      check("t2 gap1", 72'(burst_start[nb+1] - burst_end[nb]), 72'(HOLDOFF + 1));
      check("t2 gap2", 72'(burst_start[nb+2] - burst_end[nb+1]), 72'(HOLDOFF + 1));
    end

    // Randomized traffic with random out_rdy and write gaps (never fills).
    for (int p = 0; p < 30; p++)
      send_pkt($urandom_range(2, 7), 8'($urandom), 8'($urandom_range(1, 255)), 20, 1'b1);
    out_rdy = 1'b1;
    wait_drain(2000);
    check("rand fwd count", 72'(pkt_fwd_count), 72'(stat(exp_fwd)));

    // Fill: 85 three-word packets plus one header word with out_rdy=0.
    out_rdy = 1'b0;
    for (int p = 0; p < 85; p++) send_pkt(3, 8'($urandom), 8'($urandom_range(1, 255)), 0, 1'b0);
    xc = 8'($urandom);
    xd = {$urandom, $urandom};
    send_word(xc, xd);
    check("full in_rdy", 72'(in_rdy), 72'd0);
    check("wr_err before", 72'(wr_err), 72'd0);
    in_ctrl = 8'h5A; in_data = 64'hDEAD_BEEF_0BAD_F00D; in_wr = 1'b1;
    @(posedge clk); #1;
    in_wr = 1'b0;
    check("wr_err set", 72'(wr_err), 72'd1);
    out_rdy = 1'b1;
    wait_drain(2000);
    // Finish the packet whose header was the 256th word.
    ec = 8'($urandom_range(1, 255));
    ed = {$urandom, $urandom};
    exp_q.push_back({1'b0, xc, xd});
    exp_q.push_back({1'b1, ec, ed});
    exp_fwd++;
    send_word(ec, ed);
    wait_drain(100);
    check("wr_err sticky", 72'(wr_err), 72'd1);

    // Over-length 300-word packet is dropped; next packet passes intact.
    nb = burst_start.size();
    send_pkt(300, 8'h00, 8'h02, 0, 1'b0);
    send_pkt(2, 8'h33, 8'h04, 0, 1'b0);
    wait_drain(200);
    check("t4 bursts", 72'(burst_start.size()), 72'(nb + 1));
    check("t4 drop count", 72'(pkt_drop_count), 72'(stat(exp_drop)));
    check("t4 fwd count", 72'(pkt_fwd_count), 72'(stat(exp_fwd)));

    // EOP write coincides with EOP send of the previous packet.
    nb = burst_start.size();
    send_pkt(4, 8'h10, 8'h01, 0, 1'b0);
    send_pkt(4, 8'h20, 8'h03, 0, 1'b0);
    e_b = cyc;
    wait_drain(100);
    check("t6 bursts", 72'(burst_start.size()), 72'(nb + 2));
    if (burst_start.size() >= nb + 2) begin
      check("t6 same cycle", 72'(burst_end[nb]), 72'(e_b));
      check("t6 second after hold", 72'(burst_start[nb+1] - burst_end[nb]), 72'(HOLDOFF + 1));
    end

    // Reset while word 3 of a 6-word packet is on the output.
    send_pkt(6, 8'h77, 8'h08, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t5 word3 out_wr", 72'(out_wr), 72'd1);
    reset = 1'b1;
    exp_q.delete();
    exp_fwd  = 0;
    exp_drop = 0;
    #1;
    check("t5 reset out_wr", 72'(out_wr), 72'd0);
    check("t5 reset out_data", 72'(out_data), 72'd0);
    check("t5 reset in_rdy", 72'(in_rdy), 72'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("t5 release in_rdy", 72'(in_rdy), 72'd1);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_wr) seen++;
    end
    check("t5 no residue", 72'(seen), 72'd0);
    check("t5 wr_err clr", 72'(wr_err), 72'd0);
    check("t5 fwd clr", 72'(pkt_fwd_count), 72'd0);
    check("t5 drop clr", 72'(pkt_drop_count), 72'd0);
    send_pkt(5, 8'hC0, 8'h01, 0, 1'b0);
    wait_drain(100);
    check("t5 fwd after", 72'(pkt_fwd_count), 72'(stat(exp_fwd)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ingress_pkt_stager.md
Name: ingress_pkt_stager

Overview:
- Store-and-forward staging buffer directly upstream of the network-interface FIFO FSM.
- Accepts NetFPGA-style 64-bit data / 8-bit ctrl words from the MAC side and stores each packet whole.
- Forwards a packet to the FSM only once the packet is complete and the FSM is ready, as one gap-free burst, so the FSM never sees a stalled packet.
- Drops over-length packets and enforces a hold-off after each burst to cover the FSM's one-cycle registered-input lag.

Parameters:
- ADDR_W, 8, log2 of buffer depth (DEPTH = 2^ADDR_W words of 72 bits).
- MAX_PKT_WORDS, 255, maximum stored packet length in words. Must be <= DEPTH-1; checked at elaboration.
- HOLDOFF, 2, cycles after the EOP word is sent during which out_rdy is ignored.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  64  upstream data word
- in_ctrl  in  8  upstream ctrl byte
- in_wr  in  1  upstream word valid
- in_rdy  out  1  buffer can accept a word
- out_data  out  64  data to FSM in_datai
- out_ctrl  out  8  ctrl to FSM in_ctrli
- out_wr  out  1  word valid to FSM in_wri
- out_rdy  in  1  FSM in_rdy
- pkt_fwd_count  out  16  packets forwarded (optional feature)
- pkt_drop_count  out  16  packets dropped (optional feature)
- wr_err  out  1  sticky flag: in_wr was seen while in_rdy=0

Behaviour:
- Framing: a packet is one header word (any ctrl value) followed by words up to and including the first word with ctrl != 0 (EOP). Minimum packet length is 2 words.
- Write side:
  - A word is accepted when in_wr=1 and in_rdy=1.
  - in_rdy = ~full, registered. full = (stored words == DEPTH).
  - A word arriving with in_wr=1 while in_rdy=0 is discarded and sets wr_err, which stays set until reset.
- Committing a packet: wp_start marks the packet's first word. On EOP, pkt_cnt increments and wp_start moves to wp+1.
- Over-length packets: if the packet reaches MAX_PKT_WORDS+1 words without an EOP:
  - wp rewinds to wp_start;
  - DROP mode is entered and further words are consumed and discarded through EOP;
  - pkt_drop_count increments at that EOP;
  - in_rdy stays 1 during DROP unless the buffer is full.
- Read FSM states: IDLE, SEND, HOLD.
  - IDLE: when pkt_cnt > 0 and out_rdy=1, go to SEND.
  - SEND: the first word appears on out_data/out_ctrl with out_wr=1 on the cycle after out_rdy is sampled. Words are then issued every cycle with no gaps and out_rdy is ignored. After the EOP word, decrement pkt_cnt, increment pkt_fwd_count and go to HOLD.
  - HOLD: count HOLDOFF cycles with out_wr=0, then return to IDLE.
- Outputs are registered. While out_wr=0, out_data/out_ctrl hold their last value.
- Pointers wrap modulo DEPTH. Address arithmetic is ADDR_W bits wide; occupancy is ADDR_W+1 bits.
- Simultaneous EOP write and EOP send in the same cycle: pkt_cnt net change is 0.
- Reading and writing the same address in one cycle cannot occur, because only committed words are read.
- Counters saturate at 16'hFFFF.
- Reset, including mid-packet:
  - state=IDLE; all pointers, pkt_cnt, counters and wr_err cleared; DROP cleared;
  - out_wr=0, out_data=0, out_ctrl=0, in_rdy=0 during reset, in_rdy=1 on the first clock after release;
  - any partial packet is lost.

Optional Feature:
- Macro STAGER_STATS_EN.
- Defined: pkt_fwd_count and pkt_drop_count are live saturating counters as described above.
- Undefined: both ports are tied to 0, the counter logic is not built, and drop behaviour is unchanged.

Test Plan:
- Write a 4-word packet (ctrl FF,00,00,01) with out_rdy=1. Required: out_wr high for exactly 4 consecutive cycles, starting the cycle after the EOP is written and out_rdy is sampled; data matches in order; pkt_fwd_count=1.
- Write 3 back-to-back 2-word packets with out_rdy=1. Required: three bursts, each followed by exactly 2 idle cycles (HOLD); no word reordering.
- Hold out_rdy=0 and write 256 words (85 three-word packets plus 1 extra word). Required: in_rdy drops to 0 after word 256; next word with in_wr=1 sets wr_err=1.
- Write a 300-word packet with no ctrl != 0 until word 300. Required: nothing forwarded; pkt_drop_count=1; a following 2-word packet is forwarded intact.
- Assert reset for 1 cycle in the middle of SEND on word 3 of 6. Required: out_wr=0 immediately; after release, pkt_cnt=0 and in_rdy=1; new packet forwarded normally.
- Write a packet's EOP in the same cycle the previous packet's EOP is sent. Required: pkt_cnt unchanged in that cycle; second packet sent after HOLD.
